// File: rtl/alu_pkg.sv
// Shared types and constants for the sequenced ALU front-end.
// Op encodings, entry width and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int CMD_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO for alu_seq: DEPTH entries of {op,x,y}.
// Pointers carry a wrap bit to separate full from empty.
module alu_seq_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] din,
  input  logic             pop,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CMD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_seq.sv
// Queues ALU commands, drives an external ALU, returns results.
// Optional sticky carry/overflow flags: ALU_SEQ_STICKY_FLAGS_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_op,
  output logic [3:0] rsp_s,
  output logic       rsp_c,
  output logic       rsp_zero,
  output logic       rsp_ovf,
  output logic [2:0] alu_op,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  input  logic [3:0] alu_s,
  input  logic       alu_c,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  ,
  input  logic       flags_clr,
  output logic       sticky_c,
  output logic       sticky_ovf
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load;
  logic             capture;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({cmd_op, cmd_x, cmd_y}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = RESP;
        capture   = 1'b1;
        pop       = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            state_nxt = ISSUE;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_x  <= '0;
      alu_y  <= '0;
    end else if (load) begin
      {alu_op, alu_x, alu_y} <= head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_op   <= '0;
      rsp_s    <= '0;
      rsp_c    <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (capture) begin
      rsp_op   <= alu_op;
      rsp_s    <= alu_s;
      rsp_c    <= alu_c;
      rsp_zero <= alu_zero;
      rsp_ovf  <= alu_ovf;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = !empty || (state != IDLE);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic arith;
  assign arith = capture && (alu_op inside {OP_ADD, OP_SUB, OP_SLT, OP_EQ});

  // A capture setting a flag beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c   <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      sticky_c   <= (arith && alu_c)   || (sticky_c   && !flags_clr);
      sticky_ovf <= (arith && alu_ovf) || (sticky_ovf && !flags_clr);
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural 4-bit ALU.
// Build with ALU_SEQ_STICKY_FLAGS_EN to cover the sticky flags.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_op;
  logic [3:0] rsp_s;
  logic       rsp_c;
  logic       rsp_zero;
  logic       rsp_ovf;
  logic [2:0] alu_op;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [3:0] alu_s;
  logic       alu_c;
  logic       alu_zero;
  logic       alu_ovf;
  logic       busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic       flags_clr;
  logic       sticky_c;
  logic       sticky_ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op    (rsp_op),
    .rsp_s     (rsp_s),
    .rsp_c     (rsp_c),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .alu_op    (alu_op),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_s     (alu_s),
    .alu_c     (alu_c),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .busy      (busy)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    .flags_clr  (flags_clr),
    .sticky_c   (sticky_c),
    .sticky_ovf (sticky_ovf)
`endif
  );

  // Reference ALU, result packed as {s, c, zero, ovf}.
  function automatic logic [6:0] alu_ref(input logic [2:0] op,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
    int ux, uy, sx, sy, sum, dif, ssum, sdif;
    logic [3:0] s;
    logic c, z, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 7) ? ux - 16 : ux;
    sy = (uy > 7) ? uy - 16 : uy;
    sum = ux + uy;
    dif = ux + (15 - uy) + 1;
    ssum = sx + sy;
    sdif = sx - sy;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = 4'(sum);
        c = (sum > 15);
        v = (ssum > 7) || (ssum < -8);
      end
      OP_SUB: begin
        s = 4'(dif);
        c = (dif > 15);
        v = (sdif > 7) || (sdif < -8);
      end
      OP_NOT: s = ~x;
      OP_AND: s = x & y;
      OP_OR:  s = x | y;
      OP_XOR: s = x ^ y;
      OP_SLT: begin
        s = (sx < sy) ? 4'd1 : 4'd0;
        c = (dif > 15);
        v = (sdif > 7) || (sdif < -8);
      end
      default: begin
        s = (ux == uy) ? 4'd1 : 4'd0;
        c = (dif > 15);
        v = (sdif > 7) || (sdif < -8);
      end
    endcase
    if (op == OP_SLT || op == OP_EQ) z = ((dif % 16) == 0);
    else                             z = (s == 4'd0);
    return {s, c, z, v};
  endfunction

  always_comb {alu_s, alu_c, alu_zero, alu_ovf} = alu_ref(alu_op, alu_x, alu_y);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: commands in acceptance order, checked on every response.
  logic       held = 1'b0;
  logic [9:0] held_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      logic [10:0] e;
      check("busy", busy, exp_q.size() != 0);
      if (held) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_hold",
              {rsp_op, rsp_s, rsp_c, rsp_zero, rsp_ovf}, held_val);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_rsp", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          check("rsp", {rsp_op, rsp_s, rsp_c, rsp_zero, rsp_ovf},
                {e[10:8], alu_ref(e[10:8], e[7:4], e[3:0])});
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            n_rsp++;
          end
        end
      end
      held = rsp_valid && !rsp_ready;
      held_val = {rsp_op, rsp_s, rsp_c, rsp_zero, rsp_ovf};
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_op, cmd_x, cmd_y});
    end
  end

  // One command from idle, with hand-computed {s,c,zero,ovf}.
  task automatic single(input logic [2:0] op, input logic [3:0] x,
                        input logic [3:0] y, input logic [6:0] lit,
                        input bit clr);
    check("rdy_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
    check("lat_k0", rsp_valid, 0);
    @(posedge clk) #1;
    check("lat_k1", rsp_valid, 0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    flags_clr = clr;
`else
    if (clr) check("clr_unused", cmd_valid, 0);
`endif
    @(posedge clk) #1;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    check("lat_k2", rsp_valid, 1);
    check("lit_op", rsp_op, op);
    check("lit_res", {rsp_s, rsp_c, rsp_zero, rsp_ovf}, lit);
    @(posedge clk) #1;
    check("rsp_done", rsp_valid, 0);
  endtask

  function automatic logic [10:0] vec(input int i);
    logic [2:0] op;
    logic [3:0] x, y;
    op = 3'(i);
    x = 4'(i * 3 + 7);
    y = 4'(i * 5 + 1);
    return {op, x, y};
  endfunction

  initial begin
    int acc, idx, r0, t;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_x = '0;
    cmd_y = '0;
    rsp_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #2;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_op, rsp_s, rsp_c, rsp_zero, rsp_ovf}, 0);
    check("rst_alu", {alu_op, alu_x, alu_y}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", cmd_ready, 1);
    @(posedge clk) #1;

    single(OP_ADD, 4'd7, 4'd1, {4'b1000, 1'b0, 1'b0, 1'b1}, 0);
    single(OP_SUB, 4'd3, 4'd5, {4'b1110, 1'b0, 1'b0, 1'b0}, 0);
    single(OP_SLT, 4'd3, 4'd5, {4'b0001, 1'b0, 1'b0, 1'b0}, 0);
    single(OP_EQ,  4'd5, 4'd5, {4'b0001, 1'b1, 1'b1, 1'b0}, 0);
    single(OP_NOT, 4'hF, 4'h0, {4'b0000, 1'b0, 1'b1, 1'b0}, 0);
    single(OP_XOR, 4'hA, 4'h6, {4'b1100, 1'b0, 1'b0, 1'b0}, 0);

    // Back-to-back with rsp_ready high: one response every two cycles.
    idx = 0;
    r0 = n_rsp;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = (idx < 4);
      {cmd_op, cmd_x, cmd_y} = vec(idx + 3);
      @(negedge clk);
      if (cmd_valid && cmd_ready) idx++;
      @(posedge clk) #1;
    end
    cmd_valid = 1'b0;
    check("thru_rsp", n_rsp - r0, 4);

    // Backpressure: FIFO plus the held response.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      {cmd_op, cmd_x, cmd_y} = vec(acc);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk) #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepts", acc, DEPTH + 1);
    check("bp_full", cmd_ready, 0);
    r0 = n_rsp;
    rsp_ready = 1'b1;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 40) begin
      @(posedge clk) #1;
      t++;
    end
    check("bp_drain_time", t < 40, 1);
    check("bp_responses", n_rsp - r0, DEPTH + 1);

    // Reset while a response is held and three commands are queued.
    rsp_ready = 1'b0;
    acc = 0;
    t = 0;
    while (acc < 4 && t < 20) begin
      cmd_valid = 1'b1;
      {cmd_op, cmd_x, cmd_y} = vec(acc + 1);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk) #1;
      t++;
    end
    cmd_valid = 1'b0;
    check("rst_fill", acc, 4);
    check("rst_pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp", {rsp_op, rsp_s, rsp_c, rsp_zero, rsp_ovf}, 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    check("rst_mid_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    r0 = n_rsp;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_stale", n_rsp, r0);
    check("rst_idle_valid", rsp_valid, 0);
    check("rst_idle_busy", busy, 0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    single(OP_ADD, 4'd7, 4'd1, {4'b1000, 1'b0, 1'b0, 1'b1}, 0);
    check("sticky_ovf_set", sticky_ovf, 1);
    check("sticky_c_clear", sticky_c, 0);
    single(OP_AND, 4'hF, 4'h3, {4'b0011, 1'b0, 1'b0, 1'b0}, 0);
    check("sticky_ovf_keep", sticky_ovf, 1);
    flags_clr = 1'b1;
    @(posedge clk) #1;
    flags_clr = 1'b0;
    check("sticky_clr", {sticky_c, sticky_ovf}, 0);
    single(OP_SUB, 4'd5, 4'd3, {4'b0010, 1'b1, 1'b0, 1'b0}, 0);
    check("sticky_c_set", {sticky_c, sticky_ovf}, 2'b10);
    single(OP_ADD, 4'd7, 4'd1, {4'b1000, 1'b0, 1'b0, 1'b1}, 1);
    check("sticky_set_wins", {sticky_c, sticky_ovf}, 2'b01);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >= 2).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 3, cmd_x in 4, cmd_y in 4: command channel, op encoding per the package.
REQ-005 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_op out 3, rsp_s out 4, rsp_c out 1, rsp_zero out 1, rsp_ovf out 1: response channel.
REQ-006 The block SHALL have ports alu_op out 3, alu_x out 4, alu_y out 4, all registered: drive to the combinational ALU.
REQ-007 The block SHALL have ports alu_s in 4, alu_c in 1, alu_zero in 1, alu_ovf in 1: ALU results.
REQ-008 The block SHALL have port busy  output  1  high when the FIFO is non-empty or state is not IDLE.

Function
REQ-009 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready, and written to the FIFO tail.
REQ-010 cmd_ready SHALL be high iff the FIFO is not full; there is no bypass, so a pop and a push in the same cycle while full are not possible.
REQ-011 The FSM SHALL have states IDLE, ISSUE, RESP.
REQ-012 IDLE->ISSUE SHALL occur when the FIFO is non-empty; on that edge alu_op/alu_x/alu_y load from the FIFO head.
REQ-013 ISSUE->RESP SHALL occur unconditionally after one cycle; on that edge alu_s/c/zero/ovf and the head op are registered into the rsp_* outputs, and the head is popped.
REQ-014 rsp_valid SHALL be high exactly in RESP; rsp_* SHALL remain stable until rsp_ready is sampled high.
REQ-015 On RESP && rsp_ready, the FSM SHALL go to ISSUE (loading the next head) if the FIFO is non-empty, else to IDLE.
REQ-016 Minimum latency SHALL be: command accepted at edge k, rsp_valid high from edge k+2; sustained throughput one response per 2 cycles with rsp_ready tied high.
REQ-017 alu_* outputs SHALL hold their last values in IDLE and RESP.
REQ-018 FIFO pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full = equal index and differing wrap bit; empty = pointers equal.
REQ-019 Total in flight SHALL be DEPTH+1 (DEPTH queued plus one in RESP).

Reset
REQ-020 On rst_n low, the block SHALL asynchronously set: state IDLE, FIFO empty, cmd_ready 1 after release, rsp_valid 0, rsp_* 0, alu_* 0, busy 0.
REQ-021 Reset mid-operation SHALL discard queued commands and any pending response without emitting them.

Configuration
REQ-022 With macro ALU_SEQ_STICKY_FLAGS_EN defined, the block SHALL add ports flags_clr input 1, sticky_c output 1, sticky_ovf output 1.
REQ-023 The sticky registers SHALL set on the ISSUE->RESP edge when op is 000/001/110/111 and the captured alu_c/alu_ovf is 1; flags_clr clears both; set SHALL win over a same-cycle clear; reset value 0.
REQ-024 Without the macro, the block SHALL omit those ports and that logic, with no other behavioural difference.

Structure
REQ-025 The shared package alu_pkg SHALL hold the op constants OP_ADD=000, OP_SUB=001, OP_NOT=010, OP_AND=011, OP_OR=100, OP_XOR=101, OP_SLT=110, OP_EQ=111, plus the FSM state typedef.
REQ-026 The block SHALL contain one sub-module, alu_seq_fifo (parameterised DEPTH, 11-bit entries {op,x,y}); the ALU itself SHALL stay outside the block.

Verification (bench connects the existing 4-bit ALU to alu_*)
REQ-027 The bench SHALL check: OP_ADD x=7 y=1 -> rsp_s=1000, rsp_c=0, rsp_ovf=1, rsp_zero=0, rsp_valid two edges after acceptance.
REQ-028 The bench SHALL check: OP_SUB x=3 y=5 -> rsp_s=1110, rsp_c=0, rsp_ovf=0; OP_SLT x=3 y=5 -> rsp_s=0001.
REQ-029 The bench SHALL check: OP_EQ x=5 y=5 -> rsp_s=0001, rsp_zero=1, rsp_c=1.
REQ-030 The bench SHALL check: rsp_ready=0, push continuously -> exactly DEPTH+1=5 accepts then cmd_ready=0; release rsp_ready -> 5 responses in order, rsp_* stable while stalled.
REQ-031 The bench SHALL check: rst_n pulsed low while in RESP with 3 queued -> rsp_valid=0 immediately, no stale responses afterwards, busy=0.
REQ-032 The bench SHALL check, with ALU_SEQ_STICKY_FLAGS_EN: OP_ADD 7+1 sets sticky_ovf=1; OP_AND afterwards keeps it; flags_clr pulse -> 0; flags_clr coincident with an overflow capture -> stays 1.
